// File: rtl/jtframe_nvram_pkg.sv
// rtl/jtframe_nvram_pkg.sv - shared FSM state type and host address width for the NVRAM ioctl block
package jtframe_nvram_pkg;

    // Width of the MiSTer ioctl byte address bus.
    localparam int IOCTL_AW = 26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_A,
        ST_RD_D,
        ST_CLR
    } state_t;

endpackage

// File: rtl/jtframe_nvram_ioctl_if.sv
// rtl/jtframe_nvram_ioctl_if.sv - host ioctl byte bus between the frame loader and the NVRAM block
// Signals: ioctl_ram (session active), ioctl_addr (byte address), ioctl_dout (host->NVRAM byte),
//          ioctl_wr (write strobe), ioctl_din (NVRAM->host byte).
// Modports: master drives the host side, slave is the NVRAM loader/dumper.
interface jtframe_nvram_ioctl_if;
    import jtframe_nvram_pkg::*;

    logic                ioctl_ram;
    logic [IOCTL_AW-1:0] ioctl_addr;
    logic [7:0]          ioctl_dout;
    logic                ioctl_wr;
    logic [7:0]          ioctl_din;

    modport master (
        output ioctl_ram,
        output ioctl_addr,
        output ioctl_dout,
        output ioctl_wr,
        input  ioctl_din
    );

    modport slave (
        input  ioctl_ram,
        input  ioctl_addr,
        input  ioctl_dout,
        input  ioctl_wr,
        output ioctl_din
    );

endinterface

// File: rtl/jtframe_nvram_ioctl.sv
// rtl/jtframe_nvram_ioctl.sv - byte loader/dumper, clear sweep and dirty tracking for NVRAM port 1B
// Ports: clk, rst_n (async, active low); io (ioctl host bus, slave side);
//        clr_req/clr_busy (clear request and progress); game_we/dirty (port-0 write tracking);
//        nv_addr/nv_din/nv_we/nv_sel/nv_q (NVRAM port 1B, q valid one clk after addr).
module jtframe_nvram_ioctl
    import jtframe_nvram_pkg::*;
#(
    parameter int         AW      = 10,
    parameter logic [7:0] CLR_VAL = 8'hFF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    jtframe_nvram_ioctl_if.slave        io,
    input  logic                        clr_req,
    output logic                        clr_busy,
    input  logic [1:0]                  game_we,
    output logic                        dirty,
    output logic [AW:0]                 nv_addr,
    output logic [7:0]                  nv_din,
    output logic                        nv_we,
    output logic                        nv_sel,
    input  logic [7:0]                  nv_q
);

    state_t              state;
    logic                ram_q;
    logic                clr_q;
    logic                rd_valid;
    logic                rd_oor;
    logic [IOCTL_AW-1:0] rd_addr;
    logic [AW:0]         clr_cnt;

    logic in_range;
    logic wr_hit;
    logic rd_hit;
    logic clr_rise;
    logic ram_fall;

    assign in_range = (io.ioctl_addr >> (AW + 1)) == '0;
    assign wr_hit   = io.ioctl_ram & io.ioctl_wr & in_range;
    // rd_valid is cleared outside a session so that the first address of a
    // new session is always fetched, even if it equals the last one read.
    assign rd_hit   = io.ioctl_ram & ~io.ioctl_wr & (~rd_valid | (io.ioctl_addr != rd_addr));
    assign clr_rise = clr_req & ~clr_q;
    assign ram_fall = ram_q & ~io.ioctl_ram;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ram_q        <= 1'b0;
            clr_q        <= 1'b0;
            rd_valid     <= 1'b0;
            rd_oor       <= 1'b0;
            rd_addr      <= '0;
            clr_cnt      <= '0;
            clr_busy     <= 1'b0;
            dirty        <= 1'b0;
            nv_addr      <= '0;
            nv_din       <= 8'h00;
            nv_we        <= 1'b0;
            nv_sel       <= 1'b0;
            io.ioctl_din <= 8'h00;
        end else begin
            ram_q  <= io.ioctl_ram;
            clr_q  <= clr_req;
            nv_we  <= 1'b0;
            nv_sel <= io.ioctl_ram;
            if (!io.ioctl_ram) begin
                rd_valid <= 1'b0;
            end

            // Set beats clear: a game write landing as the session closes
            // still leaves the NVRAM marked as changed.
            if (|game_we) begin
                dirty <= 1'b1;
            end else if (ram_fall) begin
                dirty <= 1'b0;
            end

            // A host write takes priority in every state: it pre-empts a
            // pending read, chains directly after a write in progress, and
            // ends any clear sweep.
            if (wr_hit) begin
                state    <= ST_WR;
                nv_addr  <= io.ioctl_addr[AW:0];
                nv_din   <= io.ioctl_dout;
                nv_we    <= 1'b1;
                clr_busy <= 1'b0;
                clr_cnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rd_hit) begin
                            state    <= ST_RD_A;
                            rd_addr  <= io.ioctl_addr;
                            rd_valid <= 1'b1;
                            rd_oor   <= ~in_range;
                            nv_addr  <= io.ioctl_addr[AW:0];
                        end else if (clr_rise && !io.ioctl_ram) begin
                            state    <= ST_CLR;
                            clr_busy <= 1'b1;
                            clr_cnt  <= '0;
                            nv_addr  <= '0;
                            nv_din   <= CLR_VAL;
                            nv_we    <= 1'b1;
                            nv_sel   <= 1'b1;
                        end
                    end
                    ST_WR: begin
                        state <= ST_IDLE;
                    end
                    ST_RD_A: begin
                        state <= ST_RD_D;
                    end
                    ST_RD_D: begin
                        io.ioctl_din <= rd_oor ? 8'h00 : nv_q;
                        state        <= ST_IDLE;
                    end
                    ST_CLR: begin
                        if (io.ioctl_ram) begin
                            state    <= ST_IDLE;
                            clr_busy <= 1'b0;
                            clr_cnt  <= '0;
                        end else if (clr_cnt == '1) begin
                            state    <= ST_IDLE;
                            clr_busy <= 1'b0;
                            clr_cnt  <= '0;
                            dirty    <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                            nv_addr <= clr_cnt + 1'b1;
                            nv_din  <= CLR_VAL;
                            nv_we   <= 1'b1;
                            nv_sel  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
